// File: rtl/bcd_pkg.sv
// Shared BCD types and the double-dabble digit adjust used by every BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic bcd_digit_t add3_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_scan_mux.sv
// Free-running digit scanner: steps through the held BCD digits every REFRESH_DIV
// cycles, driving one active-low anode and the matching nibble.
module bcd_scan_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIGITS      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [RW-1:0] refresh_cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Digit follows bcd combinationally so a fresh result shows without moving the anode.
    always_comb begin
        digit = '0;
        an    = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                digit = bcd[4*i +: 4];
                an[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_convert_scan_ctrl.sv
// Iterative shift-add-3 binary-to-BCD converter with start/busy/done handshake,
// saturating overflow and a time-multiplexed 7-seg digit scan of the held result.
module bcd_convert_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     an
);

    localparam int ACCW = 4*DIGITS + 4;
    localparam int CW   = $clog2(WIDTH + 1);

    bcd_state_t        state, state_next;
    logic [WIDTH-1:0]  sreg;
    logic [ACCW-1:0]   acc, adj, acc_shift;
    logic [CW-1:0]     bit_cnt;
    logic              lost;
    logic              last_shift;
    logic              res_ovf;

    assign last_shift = (bit_cnt == CW'(WIDTH - 1));

    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < DIGITS + 1; i++)
            adj[4*i +: 4] = add3_adjust(acc[4*i +: 4]);
        acc_shift = {adj[ACCW-2:0], sreg[WIDTH-1]};
    end

    // Bits falling off the guard digit are remembered so wide operands still flag overflow.
    always_comb begin
        res_ovf = lost | adj[ACCW-1] | (acc_shift[ACCW-1 -: 4] != 4'd0);
        for (int unsigned i = 0; i < DIGITS; i++)
            if (acc_shift[4*i +: 4] > 4'd9)
                res_ovf = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            lost    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else if (state == IDLE && start) begin
            sreg    <= bin;
            acc     <= '0;
            bit_cnt <= '0;
            lost    <= 1'b0;
        end else if (state == SHIFT) begin
            sreg    <= sreg << 1;
            acc     <= acc_shift;
            bit_cnt <= bit_cnt + 1'b1;
            lost    <= lost | adj[ACCW-1];
            if (last_shift) begin
                bcd_out <= res_ovf ? {DIGITS{4'h9}} : acc_shift[4*DIGITS-1:0];
                ovf     <= res_ovf;
            end
        end
    end

    bcd_scan_mux #(
        .REFRESH_DIV (REFRESH_DIV),
        .DIGITS      (DIGITS)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .bcd   (bcd_out),
        .digit (digit),
        .an    (an)
    );

endmodule

// File: tb/tb_bcd_convert_scan_ctrl.sv
// Directed bench: handshake timing, all 6-bit operands, mid-conversion reset,
// 7-bit saturation and digit scan with a short refresh period.
module tb_bcd_convert_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [5:0] bin_a;
    logic [6:0] bin_b;
    logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [7:0] bcd_a, bcd_b;
    logic [3:0] digit_a, digit_b;
    logic [1:0] an_a, an_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bcd_convert_scan_ctrl #(.WIDTH(6), .DIGITS(2), .REFRESH_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .busy(busy_a), .done(done_a),
        .bcd_out(bcd_a), .ovf(ovf_a), .digit(digit_a), .an(an_a)
    );

    bcd_convert_scan_ctrl #(.WIDTH(7), .DIGITS(2), .REFRESH_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .busy(busy_b), .done(done_b),
        .bcd_out(bcd_b), .ovf(ovf_b), .digit(digit_b), .an(an_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gold(input int v);
        if (v > 99) return 8'h99;
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic convert(input bit wide, input int v, input logic [7:0] exp_bcd,
                           input logic exp_ovf);
        int w;
        w = wide ? 7 : 6;
        if (wide) begin start_b = 1'b1; bin_b = 7'(v); end
        else      begin start_a = 1'b1; bin_a = 6'(v); end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (i > 0) tick();
            chk("busy_during", wide ? busy_b : busy_a, 1);
            chk("done_early", wide ? done_b : done_a, 0);
        end
        tick();
        chk("done_pulse", wide ? done_b : done_a, 1);
        chk("busy_at_done", wide ? busy_b : busy_a, 0);
        chk("bcd_out", wide ? bcd_b : bcd_a, exp_bcd);
        chk("ovf", wide ? ovf_b : ovf_a, exp_ovf);
        tick();
        chk("done_one_cycle", wide ? done_b : done_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        logic [1:0] prev;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_bcd", bcd_a, 8'h00);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_an", an_a, 2'b10);
        chk("rst_digit", digit_a, 4'h0);
        chk("rst_bcd_w7", bcd_b, 8'h00);
        chk("rst_an_w7", an_b, 2'b10);
        rst = 1'b0;
        tick();

        convert(0, 45, 8'h45, 0);
        convert(0, 63, 8'h63, 0);
        convert(0, 0, 8'h00, 0);
        convert(0, 9, 8'h09, 0);
        for (int v = 0; v < 64; v++)
            convert(0, v, gold(v), 0);

        // start held high; operand changes mid-conversion
        start_a = 1'b1; bin_a = 6'd45;
        tick();
        chk("held_busy", busy_a, 1);
        tick(); tick();
        bin_a = 6'd10;
        n = 0;
        while (done_a !== 1'b1 && n < 20) begin tick(); n++; end
        chk("held_done_seen", done_a, 1);
        chk("held_bcd", bcd_a, 8'h45);
        tick();
        chk("held_idle_gap", busy_a, 0);
        tick();
        chk("held_restart", busy_a, 1);
        start_a = 1'b0;
        n = 0;
        while (done_a !== 1'b1 && n < 20) begin tick(); n++; end
        chk("held2_done_seen", done_a, 1);
        chk("held2_bcd", bcd_a, 8'h10);
        tick();

        // asynchronous reset during SHIFT
        start_a = 1'b1; bin_a = 6'd63;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_bcd", bcd_a, 8'h00);
        chk("mid_rst_ovf", ovf_a, 0);
        chk("mid_rst_an", an_a, 2'b10);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin tick(); if (done_a === 1'b1) seen++; end
        chk("mid_rst_no_done", seen, 0);
        convert(0, 45, 8'h45, 0);

        convert(1, 127, 8'h99, 1);
        convert(1, 99, 8'h99, 0);
        convert(1, 100, 8'h99, 1);

        // scan pattern on held 37
        convert(0, 37, 8'h37, 0);
        prev = an_a;
        tick();
        n = 0;
        while (!(an_a == 2'b10 && prev == 2'b01) && n < 20) begin prev = an_a; tick(); n++; end
        chk("scan_sync", n < 20, 1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                chk("scan_an0", an_a, 2'b10);
                chk("scan_digit0", digit_a, 4'h7);
                tick();
            end
            for (int i = 0; i < 4; i++) begin
                chk("scan_an1", an_a, 2'b01);
                chk("scan_digit1", digit_a, 4'h3);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
